psram_qspi_master: RTL
======================

# psram_qspi_master

Host-side QSPI controller that drives the PSRAM device model's `sck`/`ce_n`/`dio` pins. It accepts single read or write requests of 1, 2 or 4 bytes on a valid/ready port. It serialises each request as command 0xEB (quad read) or 0x38 (quad write), a 24-bit address and the data nibbles, then returns read data on a one-cycle response pulse. It sits between the SoC's memory-bus bridge and the `dio` tristate pad.

## Interface
- `DUMMY_SCK`, default 6: number of dummy `sck` cycles between address and read data.
- `clock`  in  1  system clock; `sck` runs at `clock`/2.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller idle; the request is accepted on `req_valid && req_ready`.
- `req_write`  in  1  1 = write (0x38), 0 = read (0xEB).
- `req_addr`  in  24  byte address of the first byte.
- `req_size`  in  2  0 = 1 B, 1 = 2 B, 2 = 4 B; 3 is treated as 4 B.
- `req_wdata`  in  32  write data; byte at `req_addr` is `[7:0]`, little-endian.
- `resp_valid`  out  1  one-cycle pulse when the transaction completes (reads and writes).
- `resp_rdata`  out  32  read data, little-endian; unread upper bytes are 0; held until the next response.
- `sck`  out  1  QSPI clock; idles low.
- `ce_n`  out  1  chip enable, active low.
- `dio_out`  out  4  data driven onto the pad.
- `dio_oe`  out  4  per-bit output enable for the pad.
- `dio_in`  in  4  data sampled from the pad.

## Operation
- Reset values: `sck`=0, `ce_n`=1, `dio_out`=0, `dio_oe`=0, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, FSM=IDLE.
- FSM states: IDLE → CMD → ADDR → (read: WAIT → RDATA | write: WDATA) → DONE → IDLE.
- IDLE, on accept:
  - latch write flag, address, byte count N (1/2/4) and write data;
  - drop `ce_n`;
  - drop `req_ready`.
- CMD: 8 `sck` cycles, command MSB first.
  - Command bit on `dio_out[0]`, `dio_oe`=4'b0001.
- ADDR: 6 `sck` cycles, address nibbles MSB first on `dio_out[3:0]`, `dio_oe`=4'hF.
- WAIT (read only): `DUMMY_SCK` `sck` cycles, `dio_oe`=0.
- RDATA: 2N `sck` cycles, `dio_oe`=0.
  - Each byte arrives high nibble first.
  - Bytes are assembled into `resp_rdata[8k+7:8k]` for the k-th byte.
- WDATA: 2N `sck` cycles, `dio_oe`=4'hF.
  - Byte k is taken from `wdata[8k+7:8k]` and sent high nibble first.
- DONE (one clock):
  - raise `ce_n`;
  - drive `sck`=0 and `dio_oe`=0;
  - pulse `resp_valid`;
  - `req_ready` returns to 1 on the next clock.
- The controller never splits or wraps addresses; the device increments the address per byte, and wrap past 0xFFFFFF is the device's behaviour.
- `req_valid` while busy is ignored (not accepted); there is no queueing.
- Reset mid-transaction: all outputs return to their reset values immediately (async). `ce_n`=1 terminates the device transfer. No `resp_valid` is produced.

## Timing
- Each `sck` period is 2 clocks: a low phase, then a high phase.
- `dio_out`/`dio_oe` change only on the clock edge that starts a low phase. They are stable across the rising edge of `sck`.
- `dio_in` is sampled on the clock edge that ends a high phase (`sck` falling), in RDATA only.
- The accept edge drops `ce_n`. The first `sck` rise is 2 clocks later, giving 1 clock of setup with `dio_out` = command MSB.
- Total `sck` cycles S:
  - read: 8+6+`DUMMY_SCK`+2N;
  - write: 8+6+2N.
- `resp_valid` is asserted 2S+1 clocks after the accept edge.
  - Read of 4 B: S=28, pulse at clock 57.
  - Write of 1 B: S=16, pulse at clock 33.
- `ce_n` is high for at least 2 clocks between back-to-back transactions: the DONE clock plus the IDLE clock.
- Counters: a 5-bit `sck`-cycle counter per phase, reloaded on each state entry, plus a 1-bit phase toggle.

## Structure
- Shared package `psram_pkg`:
  - state enum;
  - `CMD_READ`=8'hEB, `CMD_WRITE`=8'h38;
  - `ADDR_NIBBLES`=6.
- One sub-module, `psram_nibble_shreg`: a 32-bit shift register.
  - Operations: parallel load, shift-out of the high nibble, shift-in from `dio_in` to the low nibble.
  - Used for cmd/addr/wdata out and rdata in.
  - Byte reordering to little-endian is done in the top level.

## Test plan
- Reset mid-ADDR: assert `reset` → `ce_n`=1, `sck`=0, `dio_oe`=0, `req_ready`=1 immediately, with no `resp_valid`. The next request then completes normally.
- Write 4 B at 0x000100, wdata 0xDDCCBBAA, against the device model → `dio_out` sequence:
  - `dio_out[0]`: 0,0,1,1,1,0,0,0;
  - address nibbles: 0,0,0,1,0,0;
  - data nibbles: A,A,B,B,C,C,D,D.
  - `resp_valid` at clock 45.
- Read 4 B at 0x000100 after that write → `resp_rdata`=0xDDCCBBAA, `resp_valid` at clock 57, `dio_oe`=0 throughout WAIT/RDATA.
- Read 1 B at 0x000102 → `resp_rdata`=0x000000CC, S=22 `sck` rises.
- Read 2 B at 0xFFFFFF with the model preloaded with 0x11 at 0xFFFFFF and 0x22 at 0x000000 → `resp_rdata`=0x00002211.
- Back-to-back requests with `req_valid` held high → second accept exactly 2 clocks after the first `resp_valid`. `ce_n` is high ≥2 clocks between them, and `req_size`=3 yields 8 data nibbles.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM QSPI master.
// Latency: n/a (package only).
// Backpressure: n/a.
package psram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_RDATA,
        ST_WDATA,
        ST_DONE
    } state_t;

    localparam logic [7:0] CMD_READ     = 8'hEB;
    localparam logic [7:0] CMD_WRITE    = 8'h38;
    localparam int         ADDR_NIBBLES = 6;
    localparam logic [4:0] CMD_BITS     = 5'd8;

    // Request size code to number of data nibbles (2 per byte); code 3 is 4 bytes.
    function automatic logic [3:0] size_to_nibbles(input logic [1:0] size);
        case (size)
            2'd0:    return 4'd2;
            2'd1:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Reverse byte order so byte 0 sits in the top byte and leaves the shifter first.
    function automatic logic [31:0] swap_bytes(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // Received nibbles land MSB-first with the first byte highest; reorder to
    // little-endian and zero the bytes that were not read.
    function automatic logic [31:0] assemble_rdata(input logic [31:0] raw,
                                                   input logic [3:0]  nibs);
        case (nibs)
            4'd2:    return {24'h0, raw[7:0]};
            4'd4:    return {16'h0, raw[7:0], raw[15:8]};
            default: return {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
        endcase
    endfunction

endpackage

// File: rtl/psram_qspi_master_shreg.sv
// 32-bit nibble shift register: parallel load, shift out high nibble, shift in low nibble.
// Latency: updates on the clock edge where an operation is requested.
// Backpressure: none; load has priority over shift-in, which has priority over shift-out.
module psram_nibble_shreg
    import psram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        shift_out,
    input  logic        shift_in,
    input  logic [3:0]  din,
    output logic [31:0] q
);

    // Single register updated by one of three mutually prioritised operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 32'h0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_in) begin
            q <= {q[27:0], din};
        end else if (shift_out) begin
            q <= {q[27:0], 4'h0};
        end
    end

endmodule

// File: rtl/psram_qspi_master.sv
// QSPI master for PSRAM: serialises cmd/addr/data for single 1/2/4-byte reads and writes.
// Latency: resp_valid 2S+1 clocks after accept (S = total sck cycles of the transfer).
// Backpressure: req_ready low from accept until the clock after DONE; no queueing.
module psram_qspi_master
    import psram_pkg::*;
#(
    parameter int DUMMY_SCK = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  dio_out,
    output logic [3:0]  dio_oe,
    input  logic [3:0]  dio_in
);

    localparam logic [4:0] DUMMY_CNT = 5'(DUMMY_SCK);

    state_t      state;
    logic        ph;        // next value of sck while a transfer is running
    logic [4:0]  cnt;       // sck cycles left in the current phase
    logic        wr_r;
    logic [3:0]  nibs_r;
    logic [7:0]  cmd_r;
    logic [31:0] wdata_r;   // byte-swapped write data

    logic        sh_load;
    logic [31:0] sh_din;
    logic        sh_shift_out;
    logic        sh_shift_in;
    logic [31:0] sh_q;

    logic        accept;
    logic        fall;      // this edge ends a high phase and starts a low phase
    logic        last;

    assign accept = req_valid && req_ready;
    assign fall   = sck;
    assign last   = (cnt == 5'd1);

    psram_nibble_shreg u_shreg (
        .clk       (clock),
        .rst       (reset),
        .load      (sh_load),
        .load_data (sh_din),
        .shift_out (sh_shift_out),
        .shift_in  (sh_shift_in),
        .din       (dio_in),
        .q         (sh_q)
    );

    // Shifter control: load address on accept, step out nibbles on sck falls,
    // reload with write data (or clear for reads) at the end of the address phase.
    always_comb begin
        sh_load      = 1'b0;
        sh_din       = 32'h0;
        sh_shift_out = 1'b0;
        sh_shift_in  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    sh_load = 1'b1;
                    sh_din  = {req_addr, 8'h00};
                end
            end
            ST_CMD: begin
                if (fall && last) sh_shift_out = 1'b1;
            end
            ST_ADDR: begin
                if (fall) begin
                    if (!last) begin
                        sh_shift_out = 1'b1;
                    end else begin
                        sh_load = 1'b1;
                        sh_din  = wr_r ? {wdata_r[27:0], 4'h0} : 32'h0;
                    end
                end
            end
            ST_RDATA: begin
                if (fall) sh_shift_in = 1'b1;
            end
            ST_WDATA: begin
                if (fall && !last) sh_shift_out = 1'b1;
            end
            default: ;
        endcase
    end

    // Transfer FSM with registered pad outputs and sck generation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            sck        <= 1'b0;
            ph         <= 1'b0;
            ce_n       <= 1'b1;
            dio_out    <= 4'h0;
            dio_oe     <= 4'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            cnt        <= 5'd0;
            wr_r       <= 1'b0;
            nibs_r     <= 4'd0;
            cmd_r      <= 8'h00;
            wdata_r    <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            // The accept edge leaves ph=0, so the first clock keeps sck low
            // as command-bit setup; afterwards sck toggles every clock.
            if (state != ST_IDLE && state != ST_DONE) begin
                sck <= ph;
                ph  <= ~ph;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_CMD;
                        ce_n      <= 1'b0;
                        req_ready <= 1'b0;
                        sck       <= 1'b0;
                        ph        <= 1'b0;
                        wr_r      <= req_write;
                        nibs_r    <= size_to_nibbles(req_size);
                        wdata_r   <= swap_bytes(req_wdata);
                        cmd_r     <= req_write ? CMD_WRITE : CMD_READ;
                        dio_out   <= {3'b000, req_write ? CMD_WRITE[7] : CMD_READ[7]};
                        dio_oe    <= 4'b0001;
                        cnt       <= CMD_BITS;
                    end
                end
                ST_CMD: begin
                    if (fall) begin
                        if (last) begin
                            state   <= ST_ADDR;
                            cnt     <= 5'(ADDR_NIBBLES);
                            dio_out <= sh_q[31:28];
                            dio_oe  <= 4'hF;
                        end else begin
                            cnt     <= cnt - 5'd1;
                            dio_out <= {3'b000, cmd_r[6]};
                            cmd_r   <= {cmd_r[6:0], 1'b0};
                        end
                    end
                end
                ST_ADDR: begin
                    if (fall) begin
                        if (!last) begin
                            cnt     <= cnt - 5'd1;
                            dio_out <= sh_q[31:28];
                        end else if (wr_r) begin
                            state   <= ST_WDATA;
                            cnt     <= {1'b0, nibs_r};
                            dio_out <= wdata_r[31:28];
                        end else begin
                            dio_out <= 4'h0;
                            dio_oe  <= 4'h0;
                            if (DUMMY_SCK == 0) begin
                                state <= ST_RDATA;
                                cnt   <= {1'b0, nibs_r};
                            end else begin
                                state <= ST_WAIT;
                                cnt   <= DUMMY_CNT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (fall) begin
                        if (last) begin
                            state <= ST_RDATA;
                            cnt   <= {1'b0, nibs_r};
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (fall) begin
                        if (last) begin
                            state      <= ST_DONE;
                            ce_n       <= 1'b1;
                            sck        <= 1'b0;
                            ph         <= 1'b0;
                            dio_oe     <= 4'h0;
                            dio_out    <= 4'h0;
                            resp_valid <= 1'b1;
                            resp_rdata <= assemble_rdata({sh_q[27:0], dio_in}, nibs_r);
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (fall) begin
                        if (last) begin
                            state      <= ST_DONE;
                            ce_n       <= 1'b1;
                            sck        <= 1'b0;
                            ph         <= 1'b0;
                            dio_oe     <= 4'h0;
                            dio_out    <= 4'h0;
                            resp_valid <= 1'b1;
                        end else begin
                            cnt     <= cnt - 5'd1;
                            dio_out <= sh_q[31:28];
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
